mem_stage_ram_ctrl: RTL and testbench

MEM_STAGE_RAM_CTRL -- requirements
Module: mem_stage_ram_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_fwd_buffer.sv | 35 +++
 rtl/mem_stage_ram_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_stage_ram_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and widths for the MEM-stage SRAM controller
package mem_ctrl_pkg;

    localparam int ADDR_W              = 16;
    localparam int RAM_ADDR_W          = 18;
    localparam int DATA_W              = 16;
    localparam int WAIT_CYCLES_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_fwd_buffer.sv
// rtl/mem_fwd_buffer.sv - one-entry last-write buffer (valid, addr, data)
// Used only when MEM_WRITE_FORWARD_EN is defined.
module mem_fwd_buffer
    import mem_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_load_addr;
            r_data  <= i_load_data;
        end
    end

    assign o_hit  = r_valid && (r_addr == i_lookup_addr);
    assign o_data = r_data;

endmodule

// File: rtl/mem_stage_ram_ctrl.sv
// rtl/mem_stage_ram_ctrl.sv - MEM-stage SRAM controller (IDLE/SETUP/ACCESS/DONE)
// Optional MEM_WRITE_FORWARD_EN adds a last-write buffer that short-cuts hitting reads.
module mem_stage_ram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     dataIn,
    output logic [DATA_W-1:0]     dataOut,
    output logic                  done,
    output logic                  stall,
    output logic                  ram1OE,
    output logic                  ram1WE,
    output logic                  ram1EN,
    output logic [RAM_ADDR_W-1:0] ram1Addr,
    inout  wire  [DATA_W-1:0]     ram1Data
);

    localparam logic [1:0] LAST_CNT = 2'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_dout;
    logic              r_is_wr;
    logic              r_done;
    logic              r_oe;
    logic              r_we;
    logic              r_en;
    logic              r_drive;

    logic              w_req;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    assign w_req = memRead | memWrite;

`ifdef MEM_WRITE_FORWARD_EN
    mem_fwd_buffer u_fwd_buffer (
        .i_clk         (CLK),
        .i_rst_n       (RST),
        .i_load        ((r_state == ST_DONE) && r_is_wr),
        .i_load_addr   (r_addr),
        .i_load_data   (r_wdata),
        .i_lookup_addr (address),
        .o_hit         (w_fwd_hit),
        .o_data        (w_fwd_data)
    );
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_is_wr <= 1'b0;
            r_done  <= 1'b0;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_en    <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= address;
                        r_wdata <= dataIn;
                        r_is_wr <= memWrite;
                        // Forwarded read completes without touching the SRAM strobes
                        if (!memWrite && w_fwd_hit) begin
                            r_state <= ST_DONE;
                            r_dout  <= w_fwd_data;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                            r_en    <= 1'b0;
                            r_oe    <= memWrite;
                            r_drive <= memWrite;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    r_cnt   <= '0;
                    r_we    <= ~r_is_wr;
                end
                ST_ACCESS: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_we    <= 1'b1;
                        r_oe    <= 1'b1;
                        if (!r_is_wr) begin
                            r_dout <= ram1Data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    // Write data stays on the bus through DONE for SRAM hold time
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_en    <= 1'b1;
                    r_drive <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dataOut  = r_dout;
    assign done     = r_done;
    assign stall    = w_req & ~r_done;
    assign ram1OE   = r_oe;
    assign ram1WE   = r_we;
    assign ram1EN   = r_en;
    assign ram1Addr = {2'b00, r_addr};
    assign ram1Data = r_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_mem_stage_ram_ctrl.sv
// tb/tb_mem_stage_ram_ctrl.sv - randomized bench for mem_stage_ram_ctrl (WAIT_CYCLES 1 and 3)
module tb_mem_stage_ram_ctrl;

    localparam int W0 = 1;
    localparam int W1 = 3;

    logic        CLK;
    logic        RST;
    logic        rd0, wr0, rd1, wr1;
    logic [15:0] addr0, din0, addr1, din1;
    logic [15:0] dout0, dout1;
    logic        done0, stall0, oe0, we0, en0;
    logic        done1, stall1, oe1, we1, en1;
    logic [17:0] raddr0, raddr1;
    wire  [15:0] bus0, bus1;
    logic        probe0, probe1;

    logic [15:0] mem0 [65536];
    logic [15:0] mem1 [65536];

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] exp_dout [2];
    bit          fwd_v [2];
    logic [15:0] fwd_a [2];
    logic [15:0] ref_wr [int];

    mem_stage_ram_ctrl #(.WAIT_CYCLES(W0)) u_dut0 (
        .CLK(CLK), .RST(RST), .memRead(rd0), .memWrite(wr0), .address(addr0),
        .dataIn(din0), .dataOut(dout0), .done(done0), .stall(stall0),
        .ram1OE(oe0), .ram1WE(we0), .ram1EN(en0), .ram1Addr(raddr0), .ram1Data(bus0)
    );

    mem_stage_ram_ctrl #(.WAIT_CYCLES(W1)) u_dut1 (
        .CLK(CLK), .RST(RST), .memRead(rd1), .memWrite(wr1), .address(addr1),
        .dataIn(din1), .dataOut(dout1), .done(done1), .stall(stall1),
        .ram1OE(oe1), .ram1WE(we1), .ram1EN(en1), .ram1Addr(raddr1), .ram1Data(bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // SRAM models answer reads on EN/OE low; the probe pulls an undriven bus to 0
    assign bus0 = (!en0 && !oe0 && we0) ? mem0[raddr0[15:0]] : (probe0 ? 16'h0000 : 16'hzzzz);
    assign bus1 = (!en1 && !oe1 && we1) ? mem1[raddr1[15:0]] : (probe1 ? 16'h0000 : 16'hzzzz);

    initial begin
        for (int i = 0; i < 65536; i++) mem0[i] = 16'(i) ^ 16'h5A5A;
        forever @(posedge CLK) if (!en0 && !we0) mem0[raddr0[15:0]] = bus0;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem1[i] = 16'(i) ^ 16'h5A5A;
        forever @(posedge CLK) if (!en1 && !we1) mem1[raddr1[15:0]] = bus1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl(input int s);
        return (s == 0) ? {stall0, done0, en0, oe0, we0} : {stall1, done1, en1, oe1, we1};
    endfunction

    function automatic logic [15:0] bus_of(input int s);
        return (s == 0) ? bus0 : bus1;
    endfunction

    function automatic logic [15:0] dout_of(input int s);
        return (s == 0) ? dout0 : dout1;
    endfunction

    function automatic logic [17:0] raddr_of(input int s);
        return (s == 0) ? raddr0 : raddr1;
    endfunction

    function automatic logic [15:0] ref_rd(input int s, input logic [15:0] a);
        int k;
        k = s * 65536 + int'(a);
        return ref_wr.exists(k) ? ref_wr[k] : (a ^ 16'h5A5A);
    endfunction

    task automatic drive(input int s, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        if (s == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
        end
    endtask

    task automatic set_probe(input int s, input bit p);
        if (s == 0) probe0 = p;
        else        probe1 = p;
    endtask

    task automatic idle_check(input string tag);
        for (int s = 0; s < 2; s++) begin
            check({tag, "_ctl"}, 32'(ctl(s)), 32'h07);
            check({tag, "_bus"}, 32'(bus_of(s)), 32'h0);
        end
    endtask

    // One pipeline request held until done; expectations come from the cycle rules
    task automatic txn(input int s, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int          w;
        int          lat;
        bit          hit;
        bit          dut_drv;
        bit          ram_drv;
        logic [15:0] rv;
        logic [4:0]  ec;
        logic [15:0] eb;
        w = (s == 0) ? W0 : W1;
`ifdef MEM_WRITE_FORWARD_EN
        hit = !wr && fwd_v[s] && (fwd_a[s] == a);
`else
        hit = 1'b0;
`endif
        lat = hit ? 1 : 2 + w;
        rv  = ref_rd(s, a);
        @(posedge CLK); #1;
        drive(s, rd, wr, a, d);
        for (int c = 0; c <= lat; c++) begin
            dut_drv = !hit && wr && (c >= 1);
            ram_drv = !hit && !wr && (c >= 1) && (c < lat);
            set_probe(s, !(dut_drv || ram_drv));
            if (hit)
                ec = {c < 1, c == 1, 1'b1, 1'b1, 1'b1};
            else
                ec = {c < lat, c == lat, !(c >= 1), !ram_drv, !(wr && c >= 2 && c < lat)};
            eb = dut_drv ? d : (ram_drv ? rv : 16'h0000);
            @(negedge CLK);
            check($sformatf("ctl s%0d c%0d", s, c), 32'(ctl(s)), 32'(ec));
            check($sformatf("bus s%0d c%0d", s, c), 32'(bus_of(s)), 32'(eb));
            if (c == 1 && !hit) check("ram1Addr", 32'(raddr_of(s)), {14'h0, 2'b00, a});
            if (c == lat) check($sformatf("dataOut s%0d", s), 32'(dout_of(s)), 32'(wr ? exp_dout[s] : rv));
            @(posedge CLK); #1;
        end
        drive(s, 1'b0, 1'b0, 16'h0, 16'h0);
        set_probe(s, 1'b1);
        if (wr) begin
            ref_wr[s * 65536 + int'(a)] = d;
            fwd_v[s] = 1'b1;
            fwd_a[s] = a;
        end else begin
            exp_dout[s] = rv;
        end
        @(negedge CLK);
        idle_check("post");
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            exp_dout[s] = 16'h0;
            fwd_v[s]    = 1'b0;
            fwd_a[s]    = 16'h0;
        end
    endtask

    initial begin
        int          s;
        int          op;
        logic [15:0] a;
        RST = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        probe0 = 1'b1;
        probe1 = 1'b1;
        model_reset();
        #1 RST = 1'b0;
        @(negedge CLK);
        idle_check("reset");
        check("reset_dout0", 32'(dout0), 32'h0);
        check("reset_dout1", 32'(dout1), 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;

        txn(0, 1'b0, 1'b1, 16'h0040, 16'h1234);
        txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        txn(0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
        check("sram_word5", 32'(mem0[5]), 32'h0000BEEF);
        txn(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        txn(0, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F);
        txn(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
        txn(1, 1'b0, 1'b1, 16'h0040, 16'hCAFE);
        txn(1, 1'b1, 1'b0, 16'h0077, 16'h0000);
        txn(1, 1'b1, 1'b0, 16'h0040, 16'h0000);

        // Abort a write in ACCESS with reset, then re-issue it
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b1, 16'h0010, 16'h3C3C);
        @(posedge CLK); #1;
        probe0 = 1'b0;
        @(posedge CLK); #1;
        check("abort_access_we", 32'(we0), 32'h0);
        #2 RST = 1'b0;
        #1 check("abort_ctl", 32'(ctl(0)), 32'h17);
        probe0 = 1'b1;
        #1 check("abort_bus", 32'(bus0), 32'h0);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        model_reset();
        @(posedge CLK); #1;
        check("abort_done", 32'(done0), 32'h0);
        check("abort_dout0", 32'(dout0), 32'h0);
        check("abort_dout1", 32'(dout1), 32'h0);
        check("abort_sram", 32'(mem0[16]), 32'(16'h0010 ^ 16'h5A5A));
        RST = 1'b1;
        txn(0, 1'b0, 1'b1, 16'h0010, 16'h3C3C);
        txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000);

        for (int i = 0; i < 60; i++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'h0020 + 16'($urandom_range(0, 5));
            txn(s, op != 1, op == 1 || op == 3, a, 16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
                @(negedge CLK);
                idle_check("gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
